mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative MIPS multiply/divide unit; consumes the two register-file read ports (RD1->op_a,
//  RD2->op_b) and holds results in architectural HI/LO registers. Serves MULT, MULTU, DIV,
//  DIVU, MTHI, MTLO; MFHI/MFLO read hi/lo combinationally. Control stalls the core on busy.
// PARAMETERS
//  WIDTH   32  operand/HI/LO width; iteration count equals WIDTH
// PORTS
//  clk      in   1      clock, all state on posedge
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      launch operation selected by op
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  op_a     in   WIDTH  rs value (multiplicand / dividend)
//  op_b     in   WIDTH  rt value (multiplier / divisor)
//  hi_we    in   1      MTHI write strobe
//  lo_we    in   1      MTLO write strobe
//  wdata    in   WIDTH  MTHI/MTLO data
//  busy     out  1      operation in progress
//  done     out  1      one-cycle pulse: HI/LO just updated by an operation
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal regs=0.
//  - FSM: IDLE -> RUN on start; RUN -> FIN when counter reaches WIDTH-1; FIN -> IDLE always.
//  - IDLE: start sampled at edge N latches op, |op_a|/|op_b| (signed ops) or raw (unsigned),
//    and result signs; busy=1 from edge N. start in FIN or RUN is ignored.
//  - RUN: one iteration per cycle; multiply = shift-add over 2*WIDTH accumulator;
//    divide = restoring shift-subtract, one quotient bit per cycle.
//  - Result written to hi/lo at edge N+WIDTH (32 cycles after launch); busy=0 and done=1
//    for exactly the following cycle (FIN), then done=0.
//  - MULT/MULTU: {hi,lo}=64-bit product; MULT negates magnitude product if signs differ.
//  - DIV/DIVU: lo=quotient, hi=remainder. DIV: quotient sign = sign(a)^sign(b),
//    remainder sign = sign(a). 0x80000000 / 0xFFFFFFFF (DIV) -> lo=0x80000000, hi=0.
//  - Divide by zero: not trapped; full WIDTH cycles run; lo=all-ones magnitude quotient
//    (DIVU: 0xFFFFFFFF; DIV: sign-corrected per rule above), hi=op_a.
//  - hi_we/lo_we: write wdata at next edge only when state=IDLE and start=0; ignored when
//    busy or when start asserted same cycle (start wins). hi_we and lo_we together write both.
//  - hi/lo are stable (old values) throughout RUN; never partially updated.
//  - Reset mid-operation aborts immediately; no done pulse, hi/lo=0.
//  - Operands are registered at launch; op_a/op_b/op changes during RUN have no effect.
// CONFIGURATION
//  - MDU_FAST_MUL_EN defined: MULT/MULTU complete in one cycle using a combinational
//    WIDTH x WIDTH multiplier; start at edge N -> hi/lo written at edge N+1, busy stays 0,
//    done=1 for the cycle after edge N+1. Divides unchanged (WIDTH-cycle iterative).
//  - MDU_FAST_MUL_EN undefined: all four ops iterative, WIDTH-cycle latency as above.
// TESTING
//  - Reset: hold rst_n=0 mid-RUN -> busy=0, done=0, hi=lo=0 immediately, no later done.
//  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done 32 cycles after start.
//  - MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  - DIVU 100/0 -> lo=0xFFFFFFFF, hi=100; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  - start pulsed again while busy, plus hi_we=1 wdata=0x1234 while busy -> both ignored;
//    hi/lo equal first op's result; then MTLO 0x5A5A5A5A in IDLE -> lo=0x5A5A5A5A next edge.
//  - With MDU_FAST_MUL_EN: MULT 6*7 -> lo=42, hi=0 after 1 edge, busy never 1; DIVU 42/5
//    still takes 32 cycles -> lo=8, hi=2.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle between the core control path and
// the multiply/divide unit.
//
// Signals
//   start  : launch the operation selected by op (master -> unit)
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op_a   : rs value (multiplicand / dividend)
//   op_b   : rt value (multiplier / divisor)
//   hi_we  : MTHI write strobe
//   lo_we  : MTLO write strobe
//   wdata  : MTHI/MTLO data
//   busy   : operation in progress (unit -> master)
//   done   : one-cycle pulse, HI/LO were just updated by an operation
//   hi, lo : architectural HI/LO registers
//
// Handshake: there is no ready signal. start is a single-cycle request that
// the unit accepts only when it is idle; a start presented while an
// operation is in flight is dropped, so the master must stall on busy and
// may treat done as the completion strobe. hi_we/lo_we are accepted only
// when the unit is idle and start is low in the same cycle.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, op_a, op_b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, op_a, op_b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit with architectural HI/LO.
//
// Serves MULT, MULTU, DIV, DIVU (WIDTH iterations each) and MTHI/MTLO
// writes; MFHI/MFLO simply read bus.hi / bus.lo.
//
// Ports
//   clk       : clock, all state on posedge
//   rst_n     : asynchronous active-low reset
//   bus       : mul_div_unit_if slave modport (start/op/op_a/op_b/hi_we/
//               lo_we/wdata in; busy/done/hi/lo out)
//   dbg_state : current FSM state (0 IDLE, 1 RUN, 2 FIN)
//
// Configuration
//   MDU_FAST_MUL_EN : when defined, MULT/MULTU finish one cycle after launch
//                     through a combinational multiplier and never raise
//                     busy; divides stay iterative.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul_div_unit_if.slave        bus,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;   // negate product / quotient at the end
  logic               neg_r;   // negate remainder at the end
  logic [WIDTH-1:0]   m;       // multiplicand (mul) or divisor (div)
  // mul: {partial product, remaining multiplier bits}
  // div: {partial remainder, dividend bits shifting into quotient}
  logic [2*WIDTH-1:0] acc;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  // Launch-time operand conditioning (signed ops use magnitudes).
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    a_neg = ~bus.op[0] & bus.op_a[WIDTH-1];
    b_neg = ~bus.op[0] & bus.op_b[WIDTH-1];
    a_mag = a_neg ? (-bus.op_a) : bus.op_a;
    b_mag = b_neg ? (-bus.op_b) : bus.op_b;
  end

  // One iteration of shift-add multiply or restoring divide.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] step_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m};
    // No borrow means the divisor fits: keep the difference, quotient bit 1.
    div_ok    = ~div_diff[WIDTH];
    if (is_div) begin
      step_next = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc[WIDTH-2:0], div_ok};
    end else begin
      step_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign-corrected result, taken from the value the last iteration produces
  // so HI/LO are written in the same edge as that iteration.
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    prod_s = neg_q ? (-step_next) : step_next;
    quo_s  = neg_q ? (-step_next[WIDTH-1:0]) : step_next[WIDTH-1:0];
    rem_s  = neg_r ? (-step_next[2*WIDTH-1:WIDTH]) : step_next[2*WIDTH-1:WIDTH];
    if (is_div) begin
      res_hi = rem_s;
      res_lo = quo_s;
    end else begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end
  end

  // Single-cycle multiply path. fast_run is the RUN-cycle selector for it.
  logic               fast_run;
  logic [WIDTH-1:0]   fast_hi;
  logic [WIDTH-1:0]   fast_lo;
`ifdef MDU_FAST_MUL_EN
  logic               fast;
  logic [2*WIDTH-1:0] fast_prod;
  logic [2*WIDTH-1:0] fast_prod_s;

  always_comb begin
    fast_prod   = {{WIDTH{1'b0}}, m} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
    fast_prod_s = neg_q ? (-fast_prod) : fast_prod;
    fast_hi     = fast_prod_s[2*WIDTH-1:WIDTH];
    fast_lo     = fast_prod_s[WIDTH-1:0];
    fast_run    = fast;
  end
`else
  always_comb begin
    fast_hi  = '0;
    fast_lo  = '0;
    fast_run = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      m      <= '0;
      acc    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
`ifdef MDU_FAST_MUL_EN
      fast   <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div <= bus.op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            m      <= bus.op[1] ? b_mag : a_mag;
            acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            cnt    <= '0;
            state  <= RUN;
`ifdef MDU_FAST_MUL_EN
            fast   <= ~bus.op[1];
            busy_r <= bus.op[1];
`else
            busy_r <= 1'b1;
`endif
          end else begin
            // start takes priority over MTHI/MTLO in the same cycle.
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        RUN: begin
          if (fast_run) begin
            hi_r   <= fast_hi;
            lo_r   <= fast_lo;
            done_r <= 1'b1;
            state  <= FIN;
`ifdef MDU_FAST_MUL_EN
            fast   <= 1'b0;
`endif
          end else begin
            acc <= step_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              hi_r   <= res_hi;
              lo_r   <= res_lo;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= FIN;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed-vector bench for mul_div_unit. Stimulus pushes
// the hand-computed {hi,lo} and the expected done cycle into queues; a
// monitor pops and compares whenever done is seen.
module tb_mul_div_unit;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 32;
`endif
  localparam int LAT_DIV = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  mul_div_unit_if #(.WIDTH(W)) ifc ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  int             cyc_q[$];
  string          name_q[$];
  int             checks   = 0;
  int             failures = 0;
  int             done_cnt = 0;
  logic [W-1:0]   model_hi = '0;
  logic [W-1:0]   model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done at cycle %0d expected no done", cyc);
      end else begin
        logic [2*W-1:0] e;
        int             c;
        string          n;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        n = name_q.pop_front();
        check({n, "_result"}, {ifc.hi, ifc.lo}, e);
        check({n, "_latency"}, 64'(cyc), 64'(c));
      end
      done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_op(input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                           input int lat, input string name);
    exp_q.push_back({e_hi, e_lo});
    cyc_q.push_back(cyc + 1 + lat);
    name_q.push_back(name);
  endtask

  task automatic wait_done(input int n0, input int lat, input string name);
    for (int i = 0; i < lat + 8; i++) begin
      if (done_cnt != n0) break;
      @(negedge clk);
      #1;
    end
    if (done_cnt == n0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, lat + 8);
      exp_q.delete();
      cyc_q.delete();
      name_q.delete();
    end
  endtask

  // Launch one op, scramble the operand inputs after launch, check busy and
  // that HI/LO hold their old values mid-operation, then wait for done.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                        input int lat, input logic with_mt, input string name);
    int n0;
    @(negedge clk);
    n0 = done_cnt;
    ifc.op    = op;
    ifc.op_a  = a;
    ifc.op_b  = b;
    ifc.start = 1'b1;
    if (with_mt) begin
      ifc.hi_we = 1'b1;
      ifc.lo_we = 1'b1;
      ifc.wdata = 32'hDEAD_BEEF;
    end
    expect_op(e_hi, e_lo, lat, name);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.hi_we = 1'b0;
    ifc.lo_we = 1'b0;
    ifc.op    = ~op;
    ifc.op_a  = ~a;
    ifc.op_b  = ~b;
    check({name, "_busy"}, {63'b0, ifc.busy}, (lat > 1) ? 64'd1 : 64'd0);
    check({name, "_hold"}, {ifc.hi, ifc.lo}, {model_hi, model_lo});
    wait_done(n0, lat, name);
    model_hi = e_hi;
    model_lo = e_lo;
  endtask

  task automatic mt(input logic we_hi, input logic we_lo, input logic [W-1:0] data,
                    input string name);
    @(negedge clk);
    ifc.hi_we = we_hi;
    ifc.lo_we = we_lo;
    ifc.wdata = data;
    @(negedge clk);
    ifc.hi_we = 1'b0;
    ifc.lo_we = 1'b0;
    if (we_hi) model_hi = data;
    if (we_lo) model_lo = data;
    check(name, {ifc.hi, ifc.lo}, {model_hi, model_lo});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    ifc.start = 1'b0;
    ifc.op    = 2'b00;
    ifc.op_a  = '0;
    ifc.op_b  = '0;
    ifc.hi_we = 1'b0;
    ifc.lo_we = 1'b0;
    ifc.wdata = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset_busy",  {63'b0, ifc.busy}, 64'd0);
    check("reset_done",  {63'b0, ifc.done}, 64'd0);
    check("reset_hilo",  {ifc.hi, ifc.lo}, 64'd0);
    check("reset_state", {62'b0, dbg_state}, 64'd0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT_MUL, 1'b0, "multu_max");
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT_MUL, 1'b0, "mult_neg3x7");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV, 1'b0, "div_m7_2");
    run_op(OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, LAT_DIV, 1'b0, "divu_by0");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, LAT_DIV, 1'b0, "div_ovf");
    run_op(OP_MULT,  32'd6,         32'd7,         32'd0,         32'd42,        LAT_MUL, 1'b0, "mult_6x7");
    run_op(OP_DIVU,  32'd42,        32'd5,         32'd2,         32'd8,         LAT_DIV, 1'b0, "divu_42_5");
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, LAT_DIV, 1'b0, "div_7_m2");
    run_op(OP_DIV,   32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'h0000_0001, LAT_DIV, 1'b0, "div_neg_by0");
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, LAT_MUL, 1'b0, "mult_minsq");
    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, LAT_MUL, 1'b0, "multu_2p32");
    run_op(OP_MULTU, 32'd3,         32'd5,         32'd0,         32'd15,        LAT_MUL, 1'b1, "start_wins");

    // A second start and an MTHI while busy must both be dropped.
    @(negedge clk);
    n0 = done_cnt;
    ifc.op    = OP_DIVU;
    ifc.op_a  = 32'd1000;
    ifc.op_b  = 32'd10;
    ifc.start = 1'b1;
    expect_op(32'd0, 32'd100, LAT_DIV, "divu_busy");
    @(negedge clk);
    ifc.start = 1'b0;
    check("divu_busy_busy", {63'b0, ifc.busy}, 64'd1);
    repeat (3) @(negedge clk);
    ifc.op    = OP_MULTU;
    ifc.op_a  = 32'd2;
    ifc.op_b  = 32'd3;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.hi_we = 1'b1;
    ifc.wdata = 32'h0000_1234;
    @(negedge clk);
    ifc.hi_we = 1'b0;
    check("divu_busy_hold", {ifc.hi, ifc.lo}, {model_hi, model_lo});
    wait_done(n0, LAT_DIV, "divu_busy");
    model_hi = 32'd0;
    model_lo = 32'd100;
    repeat (40) @(negedge clk);
    check("after_busy_hilo", {ifc.hi, ifc.lo}, {model_hi, model_lo});

    mt(1'b0, 1'b1, 32'h5A5A_5A5A, "mtlo");
    mt(1'b1, 1'b0, 32'h1234_ABCD, "mthi");
    mt(1'b1, 1'b1, 32'hCAFE_F00D, "mthi_mtlo");

    // Reset in the middle of an operation: no result, no done afterwards.
    @(negedge clk);
    ifc.op    = OP_MULTU;
    ifc.op_a  = 32'hFFFF_FFFF;
    ifc.op_b  = 32'hFFFF_FFFF;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy",  {63'b0, ifc.busy}, 64'd0);
    check("midreset_done",  {63'b0, ifc.done}, 64'd0);
    check("midreset_hilo",  {ifc.hi, ifc.lo}, 64'd0);
    check("midreset_state", {62'b0, dbg_state}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
